lcd_bus_reader: RTL and testbench
=================================

# lcd_bus_reader

Read-side engine for the HD44780-style character LCD in 4-bit mode, the counterpart of the write-only display path. It issues RW=1 read cycles on the shared E/RW/RS/DB[7:4] bus and returns either the busy-flag/address-counter byte (RS=0) or a DDRAM/CGRAM data byte (RS=1). It can optionally poll the busy flag until it clears, with a bounded retry count. It sits beside display_LCD at top level; top muxes the LCD pins to this block while `bus_active`=1.

## Interface
Parameters:
- SETUP_CYC, 8: E-low cycles with RS/RW stable before the first E rise (tAS).
- EPW_CYC, 48: E-high cycles per nibble (tPW ≥ 230 ns at 200 MHz).
- GAP_CYC, 56: E-low cycles between nibbles and between poll retries.
- HOLD_CYC, 4: E-low cycles with RW still 1 after the last E fall.
- MAX_POLLS, 1000: busy-flag reads before a poll gives up.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req  in  1  start a read; accepted only on a cycle with ready=1.
- req_rs  in  1  RS value for the read: 0 = busy flag/address, 1 = data.
- req_poll  in  1  repeat busy-flag reads until bit7=0. Honoured only when req_rs=0.
- ready  out  1  idle; can accept req.
- rdata  out  8  last assembled byte, {high nibble, low nibble}.
- rvalid  out  1  one-cycle pulse when rdata is updated.
- timeout  out  1  asserted together with rvalid when a poll exhausts MAX_POLLS.
- bus_active  out  1  this block owns the LCD pins.
- db_release  out  1  FPGA DB drivers tri-stated (LCD drives DB).
- E, RW, RS  out  1 each  LCD control lines.
- DB_in  in  4  LCD DB[7:4] as read from the pad.

## Operation
- Reset (reset=0 at a clk edge): on the next edge, all outputs return to their reset values. The counters and FSM clear, and no rvalid is produced for an aborted transfer. Reset values: ready=1, rdata=0, rvalid=0, timeout=0, bus_active=0, db_release=0, E=0, RW=0, RS=0.
- FSM states: IDLE → SETUP → EH1 → GAP → EH2 → HOLD → DONE → IDLE. A poll retry goes DONE → RETRY → SETUP instead.
- IDLE, req=1 & ready=1:
  - Capture req_rs, and capture req_poll & ~req_rs as the poll flag.
  - Clear the poll counter.
  - On the same edge: RW=1, RS=captured value, db_release=1, bus_active=1, ready=0.
- req while ready=0 is ignored. req_rs and req_poll are sampled only at acceptance.
- SETUP: E=0 for SETUP_CYC cycles.
- EH1: E=1 for EPW_CYC cycles. DB_in is registered as the high nibble on the last E-high cycle, before the falling edge.
- GAP: E=0 for GAP_CYC cycles. RS and RW are held.
- EH2: E=1 for EPW_CYC cycles. The low nibble is sampled on the last E-high cycle.
- HOLD: E=0, RW=1 for HOLD_CYC cycles.
- DONE (one cycle): RW=0. rdata is loaded with {hi, lo}. The next action depends on the read and poll state:
  - Not polling, or bit7=0: rvalid=1.
  - Polling, bit7=1, and poll count+1 < MAX_POLLS: increment the count, go to RETRY. There is no rvalid.
  - Polling, bit7=1, and count+1 = MAX_POLLS: rvalid=1 and timeout=1.
- After DONE with rvalid: IDLE. On entry to IDLE: db_release=0, bus_active=0, ready=1.
  - RW falls one cycle before db_release falls, so there is no bus contention.
- RETRY: E=0, RW=1 for GAP_CYC cycles, then SETUP.
- Phase counter width: clog2 of the largest parameter. Poll counter width: clog2(MAX_POLLS+1). Counters never wrap mid-phase.

## Timing
- Cycles are counted from the accepting edge N (ready=1, req=1).
- Single read: rvalid is high in cycle N+1+SETUP_CYC+2·EPW_CYC+GAP_CYC+HOLD_CYC. With defaults this is N+165. ready=1 from N+166.
- Each poll retry adds 1+GAP_CYC+SETUP_CYC+2·EPW_CYC+GAP_CYC+HOLD_CYC cycles (221 with defaults).
- E is never high for more or fewer than EPW_CYC consecutive cycles.
- RS and RW never change while E=1.
- rvalid and timeout are single-cycle pulses. rdata holds its value until the next DONE.
- Back-to-back: req held high is accepted again at N+166. No req is lost while ready=1.

## Test plan
- Data read: req=1, req_rs=1, LCD model drives 0x4 during EH1 and 0x1 during EH2 -> rvalid at N+165, rdata=0x41, timeout=0, RS=1 throughout.
- Busy read, no poll: req_rs=0, req_poll=1 ignored? No — use req_poll=0, model returns 0x8 then 0x3 -> rdata=0x83, exactly one read, rvalid at N+165.
- Poll clears: req_rs=0, req_poll=1, BF=1 for 3 reads, then 0x0/0x5 -> rvalid only after 4th read at N+165+3·221, rdata=0x05, timeout=0.
- Poll timeout: MAX_POLLS=4, BF always 1 (0xF/0xF) -> rvalid and timeout high together after 4 reads, rdata=0xFF.
- Reset mid-transfer: reset=0 during EH1 -> next edge E=0, RW=0, db_release=0, ready=1, no rvalid. A fresh req after reset=1 reads correctly.
- Protocol checks every cycle: E high runs exactly EPW_CYC long; RS/RW stable while E=1; db_release=1 whenever RW=1; req while ready=0 produces no extra transfer.

Source files
------------

// File: rtl/lcd_bus_reader_if.sv
// Handshake and LCD pin bundle for the read-side LCD engine.
// The master side is the requester plus the LCD pad (it supplies DB_in);
// the slave side is the reader engine itself.
interface lcd_bus_reader_if;
  logic       req;
  logic       req_rs;
  logic       req_poll;
  logic       ready;
  logic [7:0] rdata;
  logic       rvalid;
  logic       timeout;
  logic       bus_active;
  logic       db_release;
  logic       E;
  logic       RW;
  logic       RS;
  logic [3:0] DB_in;

  modport master (
    output req, req_rs, req_poll, DB_in,
    input  ready, rdata, rvalid, timeout, bus_active, db_release, E, RW, RS
  );

  modport slave (
    input  req, req_rs, req_poll, DB_in,
    output ready, rdata, rvalid, timeout, bus_active, db_release, E, RW, RS
  );
endinterface

// File: rtl/lcd_bus_reader.sv
// Read-side engine for an HD44780-style LCD in 4-bit mode. Issues RW=1 read
// cycles (two E pulses per byte) and returns the busy/address byte or a data
// byte, optionally polling the busy flag with a bounded retry count.
//
// state | meaning
// IDLE  | bus released, ready for a request
// SETUP | E low, RS/RW stable before the first E rise
// EH1   | E high, high nibble sampled on the last high cycle
// GAP   | E low between the two nibbles
// EH2   | E high, low nibble sampled on the last high cycle
// HOLD  | E low, RW still high after the last E fall
// DONE  | RW low, byte published, decide retry or finish
// RETRY | E low, RW high, spacing before the next busy-flag read
module lcd_bus_reader #(
  parameter int SETUP_CYC = 8,
  parameter int EPW_CYC   = 48,
  parameter int GAP_CYC   = 56,
  parameter int HOLD_CYC  = 4,
  parameter int MAX_POLLS = 1000
) (
  input logic              clk,
  input logic              reset,
  lcd_bus_reader_if.slave  bus
);

  localparam int MAX_A  = (SETUP_CYC > EPW_CYC) ? SETUP_CYC : EPW_CYC;
  localparam int MAX_B  = (GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC;
  localparam int MAX_PH = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int PW     = $clog2(MAX_POLLS + 1);
  localparam logic [PW:0] POLL_LIMIT = MAX_POLLS[PW:0];

  typedef enum logic [2:0] {
    IDLE, SETUP, EH1, GAP, EH2, HOLD, DONE, RETRY
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] poll_cnt;
  logic [PW:0]   poll_next;
  logic          poll_en;
  logic          retry;
  logic [3:0]    hi;
  logic [3:0]    lo;
  logic          last;

  logic          ready_q;
  logic [7:0]    rdata_q;
  logic          rvalid_q;
  logic          timeout_q;
  logic          bus_active_q;
  logic          db_release_q;
  logic          e_q;
  logic          rw_q;
  logic          rs_q;

  assign last      = (cnt == '0);
  assign poll_next = {1'b0, poll_cnt} + (PW + 1)'(1);

  // Read sequencer: phase timing, nibble capture and poll decision, all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      poll_cnt     <= '0;
      poll_en      <= 1'b0;
      retry        <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      ready_q      <= 1'b1;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      timeout_q    <= 1'b0;
      bus_active_q <= 1'b0;
      db_release_q <= 1'b0;
      e_q          <= 1'b0;
      rw_q         <= 1'b0;
      rs_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req && ready_q) begin
            state        <= SETUP;
            cnt          <= CW'(SETUP_CYC - 1);
            poll_cnt     <= '0;
            poll_en      <= bus.req_poll & ~bus.req_rs;
            rs_q         <= bus.req_rs;
            rw_q         <= 1'b1;
            db_release_q <= 1'b1;
            bus_active_q <= 1'b1;
            ready_q      <= 1'b0;
          end
        end
        SETUP: begin
          if (last) begin
            state <= EH1;
            e_q   <= 1'b1;
            cnt   <= CW'(EPW_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        EH1: begin
          if (last) begin
            hi    <= bus.DB_in;
            state <= GAP;
            e_q   <= 1'b0;
            cnt   <= CW'(GAP_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (last) begin
            state <= EH2;
            e_q   <= 1'b1;
            cnt   <= CW'(EPW_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        EH2: begin
          if (last) begin
            lo    <= bus.DB_in;
            state <= HOLD;
            e_q   <= 1'b0;
            cnt   <= CW'(HOLD_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (last) begin
            // The poll decision is made here so rvalid/timeout are
            // registered into the DONE cycle together with rdata.
            state   <= DONE;
            rw_q    <= 1'b0;
            rdata_q <= {hi, lo};
            if (poll_en && hi[3] && (poll_next < POLL_LIMIT)) begin
              retry    <= 1'b1;
              poll_cnt <= poll_cnt + PW'(1);
            end else begin
              retry     <= 1'b0;
              rvalid_q  <= 1'b1;
              timeout_q <= poll_en & hi[3];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          rvalid_q  <= 1'b0;
          timeout_q <= 1'b0;
          if (retry) begin
            state <= RETRY;
            rw_q  <= 1'b1;
            cnt   <= CW'(GAP_CYC - 1);
          end else begin
            // RW already fell on entry to DONE, so DB drivers can come back now.
            state        <= IDLE;
            db_release_q <= 1'b0;
            bus_active_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        RETRY: begin
          if (last) begin
            state <= SETUP;
            cnt   <= CW'(SETUP_CYC - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.rdata      = rdata_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.timeout    = timeout_q;
  assign bus.bus_active = bus_active_q;
  assign bus.db_release = db_release_q;
  assign bus.E          = e_q;
  assign bus.RW         = rw_q;
  assign bus.RS         = rs_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: scoreboard of expected read
// results, an LCD model serving nibbles per E pulse, and a per-cycle
// protocol monitor.
module tb_lcd_bus_reader;

  localparam int EPW    = 48;
  localparam int LAT1   = 165;
  localparam int RETRYC = 221;

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         lat;
  } exp_t;

  logic clk;
  logic reset;

  lcd_bus_reader_if bus_if();

  lcd_bus_reader #(
    .SETUP_CYC(8), .EPW_CYC(EPW), .GAP_CYC(56), .HOLD_CYC(4), .MAX_POLLS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  exp_t       exp_q[$];
  logic [3:0] nib_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   acc_gap  = 0;
  int   n_acc    = 0;
  int   n_req    = 0;
  int   n_rvalid = 0;
  int   e_run    = 0;
  logic cur_rs   = 1'b0;
  logic e_prev   = 1'b0;
  logic rs_prev  = 1'b0;
  logic rw_prev  = 1'b0;
  logic rst_prev = 1'b0;
  logic lcd_e_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // LCD model: presents the next queued nibble for each E pulse, junk while E is low.
  always @(posedge clk) begin
    #1;
    if (bus_if.E && !lcd_e_prev) begin
      if (nib_q.size() > 0) bus_if.DB_in = nib_q.pop_front();
      else bus_if.DB_in = 4'h0;
    end else if (!bus_if.E) begin
      bus_if.DB_in = 4'hA;
    end
    lcd_e_prev = bus_if.E;
  end

  // Protocol monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset && rst_prev) begin
      if (bus_if.E) begin
        e_run++;
      end else if (e_run != 0) begin
        check("e_width", e_run, EPW);
        e_run = 0;
      end
      if (bus_if.E || e_prev) begin
        check("rs_stable_e", bus_if.RS, rs_prev);
        check("rw_stable_e", bus_if.RW, rw_prev);
      end
      if (bus_if.RW) begin
        check("db_release_rw", bus_if.db_release, 1);
        check("rs_value", bus_if.RS, cur_rs);
      end
      if (bus_if.ready && bus_if.req) begin
        acc_gap  = cyc - last_acc;
        last_acc = cyc;
        n_acc++;
      end
      if (bus_if.timeout) check("timeout_with_rvalid", bus_if.rvalid, 1);
      if (bus_if.rvalid) begin
        n_rvalid++;
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", bus_if.rvalid, 0);
        end else begin
          e = exp_q.pop_front();
          check("rdata", bus_if.rdata, e.data);
          check("timeout", bus_if.timeout, e.to);
          check("latency", cyc - last_acc, e.lat);
        end
      end
    end else begin
      e_run = 0;
    end
    e_prev   = bus_if.E;
    rs_prev  = bus_if.RS;
    rw_prev  = bus_if.RW;
    rst_prev = reset;
  end

  task automatic do_read(input logic rs, input logic poll, input logic [7:0] d,
                         input logic to, input int lat, input int hold);
    exp_t e;
    int a0, r0, k;
    e.data = d; e.to = to; e.lat = lat;
    exp_q.push_back(e);
    a0 = n_acc; r0 = n_rvalid; n_req++;
    bus_if.req = 1'b1; bus_if.req_rs = rs; bus_if.req_poll = poll; cur_rs = rs;
    k = 0;
    while (n_acc == a0 && k < 400) begin step(); k++; end
    check("accept_wait", n_acc, a0 + 1);
    // Stray request values while busy must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus_if.req_rs = ~rs; bus_if.req_poll = ~poll;
      step();
    end
    bus_if.req = 1'b0; bus_if.req_rs = rs; bus_if.req_poll = poll;
    k = 0;
    while (n_rvalid == r0 && k < 4000) begin step(); k++; end
    check("rvalid_wait", n_rvalid, r0 + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int a0, r0, k;
    bus_if.req = 1'b0; bus_if.req_rs = 1'b0; bus_if.req_poll = 1'b0;
    bus_if.DB_in = 4'hA;
    reset = 1'b0;
    repeat (3) step();
    check("rst_ready", bus_if.ready, 1);
    check("rst_rdata", bus_if.rdata, 8'h00);
    check("rst_rvalid", bus_if.rvalid, 0);
    check("rst_timeout", bus_if.timeout, 0);
    check("rst_bus_active", bus_if.bus_active, 0);
    check("rst_db_release", bus_if.db_release, 0);
    check("rst_E", bus_if.E, 0);
    check("rst_RW", bus_if.RW, 0);
    check("rst_RS", bus_if.RS, 0);
    reset = 1'b1;
    repeat (2) step();

    // Data read with stray request changes while busy.
    nib_q.push_back(4'h4); nib_q.push_back(4'h1);
    do_read(1'b1, 1'b0, 8'h41, 1'b0, LAT1, 20);
    // Busy-flag read without polling, bit7 set.
    nib_q.push_back(4'h8); nib_q.push_back(4'h3);
    do_read(1'b0, 1'b0, 8'h83, 1'b0, LAT1, 0);
    // Poll request on a data read is ignored even with bit7 set.
    nib_q.push_back(4'hC); nib_q.push_back(4'h7);
    do_read(1'b1, 1'b1, 8'hC7, 1'b0, LAT1, 0);
    // Poll clears on the 4th read.
    for (int i = 0; i < 3; i++) begin nib_q.push_back(4'h8); nib_q.push_back(4'h0); end
    nib_q.push_back(4'h0); nib_q.push_back(4'h5);
    do_read(1'b0, 1'b1, 8'h05, 1'b0, LAT1 + 3 * RETRYC, 5);
    // Poll exhausts MAX_POLLS=4.
    for (int i = 0; i < 8; i++) nib_q.push_back(4'hF);
    do_read(1'b0, 1'b1, 8'hFF, 1'b1, LAT1 + 3 * RETRYC, 0);

    // Back-to-back with req held high.
    e.data = 8'h3C; e.to = 1'b0; e.lat = LAT1; exp_q.push_back(e);
    e.data = 8'h69; exp_q.push_back(e);
    nib_q.push_back(4'h3); nib_q.push_back(4'hC);
    nib_q.push_back(4'h6); nib_q.push_back(4'h9);
    a0 = n_acc; r0 = n_rvalid; n_req += 2;
    bus_if.req = 1'b1; bus_if.req_rs = 1'b1; bus_if.req_poll = 1'b0; cur_rs = 1'b1;
    k = 0;
    while (n_acc < a0 + 2 && k < 1000) begin step(); k++; end
    bus_if.req = 1'b0;
    check("b2b_accepts", n_acc, a0 + 2);
    check("b2b_gap", acc_gap, LAT1 + 1);
    k = 0;
    while (n_rvalid < r0 + 2 && k < 1000) begin step(); k++; end
    check("b2b_rvalids", n_rvalid, r0 + 2);

    // Reset during EH1 aborts the read without rvalid.
    nib_q.push_back(4'h4); nib_q.push_back(4'h1);
    a0 = n_acc; n_req++;
    bus_if.req = 1'b1; bus_if.req_rs = 1'b1; cur_rs = 1'b1;
    k = 0;
    while (n_acc == a0 && k < 400) begin step(); k++; end
    bus_if.req = 1'b0;
    k = 0;
    while (!bus_if.E && k < 100) begin step(); k++; end
    check("abort_in_eh1", bus_if.E, 1);
    repeat (10) step();
    reset = 1'b0;
    step();
    check("abort_E", bus_if.E, 0);
    check("abort_RW", bus_if.RW, 0);
    check("abort_db_release", bus_if.db_release, 0);
    check("abort_ready", bus_if.ready, 1);
    check("abort_bus_active", bus_if.bus_active, 0);
    check("abort_rvalid", bus_if.rvalid, 0);
    reset = 1'b1;
    nib_q.delete();
    r0 = n_rvalid;
    repeat (200) step();
    check("abort_no_rvalid", n_rvalid, r0);

    // Fresh read after reset.
    nib_q.push_back(4'h5); nib_q.push_back(4'hA);
    do_read(1'b1, 1'b0, 8'h5A, 1'b0, LAT1, 0);
    repeat (30) step();
    check("rdata_hold", bus_if.rdata, 8'h5A);
    check("accept_count", n_acc, n_req);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
